// File: rtl/kmeans_stream_loader_if.sv
// Valid/ready stream carrying the configuration word and pixels from the
// loader (master) to the k-means core (slave).
interface kmeans_stream_loader_if #(
    parameter int PIX_W = 24
);
    logic [PIX_W-1:0] sout;
    logic             sout_valid;
    logic             sout_ready;

    modport master (output sout, output sout_valid, input sout_ready);
    modport slave  (input sout, input sout_valid, output sout_ready);
endinterface

// File: rtl/kmeans_stream_loader.sv
// Frame loader for the sequential k-means core: buffers one image, streams a
// config word plus pixels, then times the core's compute phase.
module kmeans_stream_loader #(
    parameter  int PIX_W   = 24,
    parameter  int K_W     = 4,
    parameter  int DEPTH   = 100,
    parameter  int TIMEOUT = 0,
    localparam int AW      = $clog2(DEPTH),
    localparam int SZ_W    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [PIX_W-1:0]      wr_data,
    input  logic                  start,
    input  logic                  abort,
    input  logic [K_W-1:0]        cfg_k,
    input  logic [SZ_W-1:0]       cfg_size,
    kmeans_stream_loader_if.master strm,
    input  logic                  core_strb,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           cycles
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIG  = 2'd1,
        ST_LOAD    = 2'd2,
        ST_COMPUTE = 2'd3
    } state_t;

    localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT) - 32'd1;
    localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};

    state_t            state_r, state_s;
    logic [PIX_W-1:0]  mem_r [DEPTH];
    logic [PIX_W-1:0]  sout_r, sout_s;
    logic              sout_valid_r, sout_valid_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic [31:0]       cycles_r, cycles_s;
    logic [AW-1:0]     idx_r, idx_s;
    logic [SZ_W-1:0]   n_r, n_s;

    logic              xfer_s;
    logic              start_ok_s;
    logic              last_s;
    logic              timeout_hit_s;
    logic              wr_ok_s;

    assign xfer_s        = sout_valid_r & strm.sout_ready;
    assign start_ok_s    = (cfg_size != {SZ_W{1'b0}}) &&
                           (32'(cfg_size) <= 32'(DEPTH)) &&
                           (cfg_k != {K_W{1'b0}});
    assign last_s        = ((SZ_W'(idx_r) + SZ_W'(1)) == n_r);
    assign timeout_hit_s = (TIMEOUT != 0) && (cycles_r == TO_LAST);
    // Writes are locked out for the whole frame so a rerun sees the same image.
    assign wr_ok_s       = wr_en && !busy_r && (32'(wr_addr) < 32'(DEPTH));

    // Pixel buffer write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            sout_r       <= {PIX_W{1'b0}};
            sout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            cycles_r     <= 32'd0;
            idx_r        <= {AW{1'b0}};
            n_r          <= {SZ_W{1'b0}};
        end else begin
            state_r      <= state_s;
            sout_r       <= sout_s;
            sout_valid_r <= sout_valid_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            err_r        <= err_s;
            cycles_r     <= cycles_s;
            idx_r        <= idx_s;
            n_r          <= n_s;
        end
    end

    // Next-state selection; abort wins over start and the core strobe.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && start_ok_s) begin
                        state_s = ST_CONFIG;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_CONFIG: begin
                    if (xfer_s) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_CONFIG;
                    end
                end
                ST_LOAD: begin
                    if (xfer_s && last_s) begin
                        state_s = ST_COMPUTE;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end
                ST_COMPUTE: begin
                    if (core_strb || timeout_hit_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_COMPUTE;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and frame counters.
    always_comb begin
        sout_s       = sout_r;
        sout_valid_s = sout_valid_r;
        done_s       = 1'b0;
        err_s        = 1'b0;
        cycles_s     = cycles_r;
        idx_s        = idx_r;
        n_s          = n_r;
        if (abort) begin
            sout_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && start_ok_s) begin
                        n_s          = cfg_size;
                        cycles_s     = 32'd0;
                        sout_s       = PIX_W'({cfg_k, cfg_size});
                        sout_valid_s = 1'b1;
                    end else if (start) begin
                        err_s = 1'b1;
                    end else begin
                        sout_valid_s = 1'b0;
                    end
                end
                ST_CONFIG: begin
                    if (xfer_s) begin
                        sout_s = mem_r[IDX_ZERO];
                        idx_s  = IDX_ZERO;
                    end else begin
                        sout_s = sout_r;
                    end
                end
                ST_LOAD: begin
                    if (xfer_s && last_s) begin
                        sout_valid_s = 1'b0;
                    end else if (xfer_s) begin
                        idx_s  = idx_r + AW'(1);
                        sout_s = mem_r[idx_r + AW'(1)];
                    end else begin
                        sout_s = sout_r;
                    end
                end
                ST_COMPUTE: begin
                    if (core_strb) begin
                        done_s = 1'b1;
                    end else if (timeout_hit_s) begin
                        cycles_s = 32'(TIMEOUT);
                        err_s    = 1'b1;
                    end else if (cycles_r != 32'hFFFF_FFFF) begin
                        cycles_s = cycles_r + 32'd1;
                    end else begin
                        cycles_s = cycles_r;
                    end
                end
                default: begin
                    sout_valid_s = 1'b0;
                end
            endcase
        end
    end

    assign busy_s = (state_s != ST_IDLE);

    assign strm.sout       = sout_r;
    assign strm.sout_valid = sout_valid_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign err             = err_r;
    assign cycles          = cycles_r;

endmodule

// File: tb/tb_kmeans_stream_loader.sv
// Randomised self-checking bench for kmeans_stream_loader; a reference image
// and per-frame expected word list are kept in plain arrays and queues.
module tb_kmeans_stream_loader;

    localparam int PIX_W   = 24;
    localparam int K_W     = 4;
    localparam int DEPTH   = 100;
    localparam int TIMEOUT = 1000;
    localparam int AW      = 7;
    localparam int SZ_W    = 7;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              start;
    logic              abort;
    logic [K_W-1:0]    cfg_k;
    logic [SZ_W-1:0]   cfg_size;
    logic              core_strb;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       cycles;

    kmeans_stream_loader_if #(.PIX_W(PIX_W)) strm ();

    kmeans_stream_loader #(
        .PIX_W(PIX_W), .K_W(K_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .abort(abort), .cfg_k(cfg_k),
        .cfg_size(cfg_size), .strm(strm), .core_strb(core_strb),
        .busy(busy), .done(done), .err(err), .cycles(cycles)
    );

    always #5 clk = ~clk;

    logic [PIX_W-1:0] mbuf [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_px(input int addr, input logic [PIX_W-1:0] data, input bit taken);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        if (taken) mbuf[addr] = data;
    endtask

    // Leaves the caller at the negedge of the first cycle after the start edge.
    task automatic do_start(input int k, input int n);
        @(negedge clk);
        start    = 1'b1;
        cfg_k    = K_W'(k);
        cfg_size = SZ_W'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode: 0 ready always, 1 ready toggles 1,0,..., 2 random ready.
    // stop_kind: 0 none, 1 abort, 2 reset, applied while word stop_pos is offered.
    task automatic stream_frame(input int k, input int n, input int mode,
                                input int stop_pos, input int stop_kind, input int strb_pos);
        logic [PIX_W-1:0] w[$];
        int pos = 0;
        int c   = 1;
        bit rdy;
        w.push_back(PIX_W'((k << SZ_W) | n));
        for (int i = 0; i < n; i++) w.push_back(mbuf[i]);
        while (pos < n + 1 && c < 4000) begin
            check("valid", {63'd0, strm.sout_valid}, 64'd1);
            check("busy", {63'd0, busy}, 64'd1);
            check($sformatf("word%0d", pos), {40'd0, strm.sout}, {40'd0, w[pos]});
            if (pos == stop_pos && stop_kind == 1) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_valid", {63'd0, strm.sout_valid}, 64'd0);
                check("abort_busy", {63'd0, busy}, 64'd0);
                check("abort_pulse", {62'd0, done, err}, 64'd0);
                return;
            end
            if (pos == stop_pos && stop_kind == 2) begin
                reset_n = 1'b0;
                #1;
                check("rst_out", {6'd0, strm.sout, strm.sout_valid, busy, done, err, cycles}, 64'd0);
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            core_strb = (pos == strb_pos);
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (c % 2) == 1;
            else                rdy = 1'($urandom_range(0, 1));
            strm.sout_ready = rdy;
            if (rdy) pos++;
            @(negedge clk);
            c++;
        end
        core_strb       = 1'b0;
        strm.sout_ready = 1'b1;
        check("xfers", 64'(pos), 64'(n + 1));
        check("valid_low", {63'd0, strm.sout_valid}, 64'd0);
        check("compute_busy", {63'd0, busy}, 64'd1);
        if (mode == 0) check("latency", 64'(c), 64'(n + 2));
    endtask

    // Called at COMPUTE cycle 1. strb_at = 0 waits for the timeout instead.
    task automatic compute_phase(input int strb_at, input int wr_at);
        int j;
        wr_addr = AW'(5);
        wr_data = 24'hABCDEF;
        if (strb_at != 0) begin
            for (j = 1; j < strb_at; j++) begin
                wr_en = (j == wr_at);
                check("no_done", {62'd0, done, err}, 64'd0);
                @(negedge clk);
            end
            wr_en     = 1'b0;
            core_strb = 1'b1;
            @(negedge clk);
            core_strb = 1'b0;
            check("done", {63'd0, done}, 64'd1);
            check("done_err", {63'd0, err}, 64'd0);
            check("done_busy", {63'd0, busy}, 64'd0);
            check("cycles", {32'd0, cycles}, 64'(strb_at - 1));
            @(negedge clk);
            check("done_pulse", {63'd0, done}, 64'd0);
        end else begin
            for (j = 1; j <= TIMEOUT + 100; j++) begin
                wr_en = (j == wr_at);
                if (err) break;
                @(negedge clk);
            end
            wr_en = 1'b0;
            check("to_latency", 64'(j), 64'(TIMEOUT + 1));
            check("to_cycles", {32'd0, cycles}, 64'(TIMEOUT));
            check("to_busy", {63'd0, busy}, 64'd0);
            check("to_done", {63'd0, done}, 64'd0);
            @(negedge clk);
            check("to_pulse", {63'd0, err}, 64'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pairs_n [3] = '{0, 101, 50};
        int pairs_k [3] = '{15, 15, 0};
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; abort = 1'b0; cfg_k = '0; cfg_size = '0;
        core_strb = 1'b0; strm.sout_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", {6'd0, strm.sout, strm.sout_valid, busy, done, err, cycles}, 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) write_px(i, PIX_W'(i), 1'b1);
        write_px(120, 24'hFFFFFF, 1'b0);

        // Basic frame with exact latency and 37th-cycle strobe.
        do_start(15, 100);
        check("cfg_word", {40'd0, strm.sout}, 64'h7E4);
        stream_frame(15, 100, 0, -1, 0, -1);
        compute_phase(37, 0);

        // Backpressure.
        do_start(15, 100);
        stream_frame(15, 100, 1, -1, 0, -1);
        compute_phase(5, 0);

        // Rejected starts.
        for (int t = 0; t < 3; t++) begin
            do_start(pairs_k[t], pairs_n[t]);
            check("bad_err", {63'd0, err}, 64'd1);
            check("bad_valid", {63'd0, strm.sout_valid}, 64'd0);
            check("bad_busy", {63'd0, busy}, 64'd0);
            @(negedge clk);
            check("bad_pulse", {62'd0, err, busy}, 64'd0);
        end

        // Timeout, strobe ignored in LOAD, write while busy ignored.
        do_start(3, 100);
        stream_frame(3, 100, 0, -1, 0, 30);
        compute_phase(0, 5);

        // Rerun: pixel 5 unchanged.
        do_start(3, 100);
        stream_frame(3, 100, 0, -1, 0, -1);
        compute_phase(10, 0);

        // Reset and abort while pixel 50 is offered, then full restream.
        do_start(15, 100);
        stream_frame(15, 100, 0, 51, 2, -1);
        do_start(15, 100);
        stream_frame(15, 100, 0, 51, 1, -1);
        do_start(15, 100);
        stream_frame(15, 100, 0, -1, 0, -1);
        compute_phase(20, 0);

        // Abort beats strobe in COMPUTE.
        do_start(2, 4);
        stream_frame(2, 4, 0, -1, 0, -1);
        repeat (2) @(negedge clk);
        abort = 1'b1; core_strb = 1'b1;
        @(negedge clk);
        abort = 1'b0; core_strb = 1'b0;
        check("abort_strb", {62'd0, done, err}, 64'd0);
        check("abort_strb_busy", {63'd0, busy}, 64'd0);

        // Abort beats start in IDLE.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; cfg_k = 4'd5; cfg_size = 7'd10;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start", {61'd0, busy, strm.sout_valid, err}, 64'd0);

        // Smallest frame.
        do_start(1, 1);
        stream_frame(1, 1, 0, -1, 0, -1);
        compute_phase(1, 0);

        // Random frames with random image updates and random backpressure.
        for (int f = 0; f < 6; f++) begin
            int k = $urandom_range(1, 15);
            int n = $urandom_range(1, 100);
            for (int i = 0; i < 10; i++) write_px($urandom_range(0, DEPTH - 1), PIX_W'($urandom), 1'b1);
            do_start(k, n);
            stream_frame(k, n, 2, -1, 0, -1);
            compute_phase($urandom_range(1, 50), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
